// File: rtl/lsu_align.sv
// lsu_align: RV32 load/store aligner that turns byte-addressed requests into word accesses with lane masks,
// splitting word-crossing accesses in two and sign/zero-extending load results.
module lsu_align #(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_req,
   input  logic        I_we,
   input  logic [2:0]  I_funct3,
   input  logic [31:0] I_addr,
   input  logic [31:0] I_wdata,
   output logic        O_ready,
   output logic        O_done,
   output logic        O_err,
   output logic [31:0] O_rdata,
   output logic [31:0] O_maddr,
   output logic [31:0] O_mdata,
   output logic [3:0]  O_mmask,
   output logic        O_mwe,
   input  logic [31:0] I_mdata
);
   typedef enum logic [1:0] {IDLE, ACC1, ACC2, WAIT} state_t;
   state_t      r_state, w_state;
   logic        r_we, r_split;
   logic [2:0]  r_f3;
   logic [1:0]  r_off;
   logic [3:0]  r_mask_hi;
   logic [31:0] r_data_hi, r_w0;
   logic [3:0]  w_smask;
   logic [7:0]  w_m8;
   logic [63:0] w_wd;
   logic        w_split, w_rej, w_done, w_err, w_mwe;
   logic [31:0] w_lo, w_sh, w_ext, w_rdata, w_maddr, w_mdata;
   logic [3:0]  w_mmask;
   assign w_smask = I_funct3[1:0] == 2'b00 ? 4'b0001 : I_funct3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
   assign w_m8    = {4'b0000, w_smask} << I_addr[1:0];
   assign w_wd    = {32'b0, I_wdata} << {I_addr[1:0], 3'b000};
   assign w_split = |w_m8[7:4];
   assign w_rej   = (I_funct3[1:0] == 2'b11) | (I_funct3[2] & (I_we | I_funct3[1])) | (w_split & !ALLOW_MISALIGNED);
   // For an aligned load both halves come from the single word now on I_mdata; upper bytes get masked off.
   assign w_lo    = r_split ? r_w0 : I_mdata;
   assign w_sh    = 32'({I_mdata, w_lo} >> {r_off, 3'b000});
   assign w_ext   = r_f3[1:0] == 2'b00 ? {{24{~r_f3[2] & w_sh[7]}}, w_sh[7:0]} :
                    r_f3[1:0] == 2'b01 ? {{16{~r_f3[2] & w_sh[15]}}, w_sh[15:0]} : w_sh;
   always_comb begin
      w_state = r_state;
      w_done  = 1'b0;
      w_err   = 1'b0;
      w_rdata = 32'h0;
      w_maddr = O_maddr;
      w_mdata = O_mdata;
      w_mmask = 4'h0;
      w_mwe   = 1'b0;
      case (r_state)
         IDLE: if (I_req) begin
            if (w_rej) begin
               w_done = 1'b1;
               w_err  = 1'b1;
            end else begin
               w_state = ACC1;
               w_maddr = {I_addr[31:2], 2'b00};
               w_mdata = w_wd[31:0];
               w_mmask = w_m8[3:0];
               w_mwe   = I_we;
            end
         end
         ACC1: if (r_split) begin
            w_state = ACC2;
            w_maddr = O_maddr + 32'd4;
            w_mdata = r_data_hi;
            w_mmask = r_mask_hi;
            w_mwe   = r_we;
         end else begin
            w_state = r_we ? IDLE : WAIT;
            w_done  = r_we;
         end
         ACC2: begin
            w_state = r_we ? IDLE : WAIT;
            w_done  = r_we;
         end
         default: begin
            w_state = IDLE;
            w_done  = 1'b1;
            w_rdata = w_ext;
         end
      endcase
   end
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_state <= IDLE;
         O_ready <= 1'b1;
         O_done  <= 1'b0;
         O_err   <= 1'b0;
         O_rdata <= 32'h0;
         O_maddr <= 32'h0;
         O_mdata <= 32'h0;
         O_mmask <= 4'h0;
         O_mwe   <= 1'b0;
      end else begin
         r_state <= w_state;
         O_ready <= w_state == IDLE;
         O_done  <= w_done;
         O_err   <= w_err;
         O_rdata <= w_rdata;
         O_maddr <= w_maddr;
         O_mdata <= w_mdata;
         O_mmask <= w_mmask;
         O_mwe   <= w_mwe;
      end
   end
   always_ff @(posedge I_clk) begin
      if (r_state == IDLE && I_req) begin
         r_we      <= I_we;
         r_f3      <= I_funct3;
         r_off     <= I_addr[1:0];
         r_split   <= w_split;
         r_mask_hi <= w_m8[7:4];
         r_data_hi <= w_wd[63:32];
      end
      if (r_state == ACC2) r_w0 <= I_mdata;
   end
endmodule
